// File: rtl/jump_target_encoder.sv
// Packs an absolute jump destination into a J-type word {opcode, dest[27:2]} and flags unreachable or misaligned targets.
// Latency: 2 registers. A request accepted at edge N produces out_valid after edge N+1 when there is no stall.
// Backpressure: S2 holds while out_ready=0 and S1 fills behind it. in_ready drops once both stages are full, so at most 2 items are outstanding.
//
// Ports: clk/rst_n (async, active-low); in_valid/in_ready/in_pc_plus4/in_dest/in_link request side;
//        out_valid/out_ready/out_instr/out_err_align/out_err_region result side;
//        err_cnt (only with JTE_ERR_CNT_EN defined) saturating count of errored output handshakes.
// Optional feature macro: JTE_ERR_CNT_EN
module jump_target_encoder #(
    parameter logic [5:0] OPCODE_J   = 6'h02,
    parameter logic [5:0] OPCODE_JAL = 6'h03
`ifdef JTE_ERR_CNT_EN
    ,
    parameter int unsigned CNT_W = 16
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc_plus4,
    input  logic [31:0] in_dest,
    input  logic        in_link,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        out_err_align,
    output logic        out_err_region
`ifdef JTE_ERR_CNT_EN
    ,
    output logic [CNT_W-1:0] err_cnt
`endif
);

    // Stage 1 (check) state
    logic        s1_valid;
    logic [25:0] s1_target;
    logic [5:0]  s1_opc;
    logic        s1_align;
    logic        s1_region;

    // Stage 2 (output) valid; data lives directly in the out_* registers
    logic        s2_valid;

    logic        s2_free;
    logic        in_fire;

    // Only the region nibble of PC+4 matters; the rest is deliberately ignored.
    logic        unused_pc_bits;
    assign unused_pc_bits = ^in_pc_plus4[27:0];

    assign out_valid = s2_valid;
    assign s2_free   = !s2_valid || out_ready;
    // Gated by rst_n so nothing can be accepted while reset is asserted.
    assign in_ready  = rst_n && (!s1_valid || s2_free);
    assign in_fire   = in_valid && in_ready;

    // Stage 1: a new accept always wins; otherwise S1 empties when it moves to S2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_target <= '0;
            s1_opc    <= '0;
            s1_align  <= 1'b0;
            s1_region <= 1'b0;
        end else if (in_fire) begin
            s1_valid  <= 1'b1;
            s1_target <= in_dest[27:2];
            s1_opc    <= in_link ? OPCODE_JAL : OPCODE_J;
            s1_align  <= (in_dest[1:0] != 2'b00);
            s1_region <= (in_dest[31:28] != in_pc_plus4[31:28]);
        end else if (s1_valid && s2_free) begin
            s1_valid  <= 1'b0;
        end
    end

    // Stage 2: only updates when free, which keeps out_* stable during a stall.
    // When S1 is empty the data registers keep their last value; out_valid qualifies them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid       <= 1'b0;
            out_instr      <= '0;
            out_err_align  <= 1'b0;
            out_err_region <= 1'b0;
        end else if (s2_free) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_instr      <= (s1_align || s1_region) ? 32'h0 : {s1_opc, s1_target};
                out_err_align  <= s1_align;
                out_err_region <= s1_region;
            end
        end
    end

`ifdef JTE_ERR_CNT_EN
    // Counts errored items as they leave, saturating at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (s2_valid && out_ready && (out_err_align || out_err_region)
                     && (err_cnt != {CNT_W{1'b1}})) begin
            err_cnt <= err_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end
`endif

endmodule
